ghash_seq: RTL and testbench
============================

Name: ghash_seq

Overview:
- Sequencing controller that runs GHASH accumulation Y <= (Y xor X_i) * H over a stream of 128-bit blocks.
- Instantiates one combinational gf_mul_128 (carry-less 128-bit multiply plus GCM reduction, GCM bit order) and treats it as a MUL_LAT-cycle multicycle path.
- Provides hash-key load, block-stream handshake, last-block termination and a held tag output.
- Sits between the GCM block-cipher datapath and the tag comparator/emitter.

Parameters:
- MUL_LAT, 2, cycles the multiplier operands are held before the product is captured; legal range 1..15.
- CNT_W, 32, width of the processed-block counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- h_load  input  1  load h_in into the H register; honoured only in IDLE
- h_in  input  128  hash subkey H, GCM bit order (bit 127 = x^0)
- start  input  1  begin a new hash: clears Y; honoured only in IDLE
- in_valid  input  1  block available
- in_ready  output  1  block accepted when in_valid && in_ready
- in_data  input  128  block X_i, GCM bit order
- in_last  input  1  marks the final block, sampled with the handshake
- out_valid  output  1  tag available
- out_ready  input  1  tag consumed when out_valid && out_ready
- out_tag  output  128  final Y
- busy  output  1  high in any state other than IDLE
- blk_cnt  output  CNT_W  blocks multiplied since the last start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; H, Y, operand register, last flag, wait counter, blk_cnt = 0; in_ready=0, out_valid=0, busy=0, out_tag=0.
- IDLE:
  - h_load=1 -> H <= h_in at the next edge.
  - start=1 -> Y <= 0, blk_cnt <= 0, go to ACCEPT.
  - h_load and start in the same cycle: both take effect; the new H is used for the first block.
  - in_valid is ignored; in_ready=0.
- ACCEPT: in_ready=1 (registered state decode, not combinational from in_valid). On handshake:
  - op <= Y xor in_data
  - last <= in_last
  - wait <= MUL_LAT-1
  - go to MUL
- MUL:
  - in_ready=0. Multiplier inputs a=op, b=H, both register outputs and stable for the whole state.
  - wait>0 -> decrement.
  - wait==0 -> Y <= gf_mul_128(op,H), blk_cnt <= blk_cnt+1 (wraps modulo 2^CNT_W), go to DONE if last else ACCEPT.
- DONE:
  - out_valid=1 and out_tag=Y, held stable until out_ready.
  - On handshake -> IDLE; out_valid drops the next cycle. out_tag keeps its value until the next start.
- Timing:
  - Handshake in cycle t -> Y updated at the edge ending cycle t+MUL_LAT.
  - in_ready reasserts in cycle t+MUL_LAT+1.
  - Throughput is one block per MUL_LAT+1 cycles.
  - For a last block, out_valid is high in cycle t+MUL_LAT+1.
- h_load and start outside IDLE are ignored; no effect on H, Y or state.
- in_last on a non-handshake cycle is ignored.
- A zero-length hash is not supported; at least one block with in_last is required.
- rst_n asserted mid-operation aborts immediately to reset values, including H; software reloads H.
- blk_cnt is not saturating.

Test Plan:
- Reset then idle: all outputs 0. Load H=0 via h_load, start, send 3 arbitrary blocks (last on the 3rd) -> out_tag=0, blk_cnt=3.
- Identity: H=128'h8000...0000, blocks 128'h0123..., 128'hFFFF...0000 (last) -> out_tag = XOR of both blocks.
- Reduction: H=128'h4000...0000 (x), single block 128'h0000...0001 (x^127, last) -> out_tag=128'hE100_0000_...0000.
- Latency with MUL_LAT=3:
  - in_valid held high -> handshakes 4 cycles apart, out_valid exactly 4 cycles after the last handshake.
  - out_ready low for 5 cycles -> out_tag and out_valid stable throughout.
- Ignored controls: h_load with a new H while in MUL and start while in DONE -> tag unchanged versus a run without them; a subsequent run in IDLE uses the old H.
- Async reset asserted mid-MUL -> all outputs 0 immediately. After release, a fresh h_load/start run produces the correct tag.

Source files
------------

// File: rtl/ghash_seq.sv
// GHASH sequencer: Y <= (Y ^ X_i) * H over a block stream, with one shared
// combinational GF(2^128) multiplier treated as a MUL_LAT-cycle multicycle path.

module gf_mul_128 (
  input  logic [127:0] a_i,
  input  logic [127:0] b_i,
  output logic [127:0] p_o
);
  // GCM bit order: bit 127 is x^0, so a right shift multiplies by x.
  localparam logic [127:0] R_POLY = {8'hE1, 120'd0};

  logic [127:0] z;
  logic [127:0] v;

  always_comb begin
    z = '0;
    v = b_i;
    for (int i = 0; i < 128; i++) begin
      if (a_i[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
    end
    p_o = z;
  end
endmodule

module ghash_seq #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               h_load,
  input  logic [127:0]       h_in,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_tag,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_cnt,
  output logic [1:0]         state_dbg
);
  // Handshakes: a transfer happens in a cycle where valid && ready are both
  // high at the rising edge; ready/valid here are pure decodes of the state.

  typedef enum logic [1:0] {IDLE, ACCEPT, MUL, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

  state_t             state_q, state_d;
  logic [127:0]       h_q, h_d;
  logic [127:0]       y_q, y_d;
  logic [127:0]       op_q, op_d;
  logic               last_q, last_d;
  logic [3:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       prod;

  gf_mul_128 u_mul (
    .a_i (op_q),
    .b_i (h_q),
    .p_o (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      last_q  <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      y_q     <= y_d;
      op_q    <= op_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    y_d     = y_q;
    op_d    = op_q;
    last_d  = last_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (h_load) h_d = h_in;
        if (start) begin
          y_d     = '0;
          cnt_d   = '0;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          op_d    = y_q ^ in_data;
          last_d  = in_last;
          wait_d  = LAT_M1;
          state_d = MUL;
        end
      end
      MUL: begin
        // op_q and h_q stay frozen here, giving the multiplier MUL_LAT cycles.
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          y_d     = prod;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = last_q ? DONE : ACCEPT;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_tag   = y_q;
  assign blk_cnt   = cnt_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_ghash_seq.sv
// Bench for ghash_seq: directed table, randomized runs against a polynomial
// reference model, latency/hold checks, ignored controls and async reset.

module tb_ghash_seq;
  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 32;
  localparam int MAX_CYC = 20000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               h_load = 1'b0;
  logic [127:0]       h_in = '0;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [127:0]       in_data = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [127:0]       out_tag;
  logic               busy;
  logic [CNT_W-1:0]   blk_cnt;
  logic [1:0]         state_dbg;

  ghash_seq #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_load    (h_load),
    .h_in      (h_in),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .busy      (busy),
    .blk_cnt   (blk_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];
  logic [127:0] cur_blk[$];

  initial begin
    #(MAX_CYC * 10);
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Multiply as ordinary polynomials (bit i = x^i) and reduce mod
  // x^128 + x^7 + x^2 + x + 1, converting from/to GCM bit order at the edges.
  function automatic logic [127:0] gmul_ref(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ar, br, r;
    logic [254:0] p;
    for (int i = 0; i < 128; i++) begin
      ar[i] = a[127-i];
      br[i] = b[127-i];
    end
    p = '0;
    for (int i = 0; i < 128; i++)
      if (ar[i]) p = p ^ (255'(br) << i);
    for (int k = 254; k >= 128; k--) begin
      if (p[k]) begin
        p[k]       = 1'b0;
        p[k - 128] = ~p[k - 128];
        p[k - 127] = ~p[k - 127];
        p[k - 126] = ~p[k - 126];
        p[k - 121] = ~p[k - 121];
      end
    end
    for (int i = 0; i < 128; i++) r[127-i] = p[i];
    return r;
  endfunction

  function automatic logic [127:0] ghash_ref(input logic [127:0] h, input logic [127:0] q[$]);
    logic [127:0] y;
    y = '0;
    foreach (q[i]) y = gmul_ref(y ^ q[i], h);
    return y;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  // Runs one hash over cur_blk. inject pulses h_load (new H) during MUL and
  // start during DONE; both must be ignored.
  task automatic run_hash(input string name, input logic [127:0] h, input bit do_load,
                          input bit inject, input int hold, input bit chk_lat,
                          input logic [127:0] exp);
    int hs_cyc, prev_hs, t;
    logic [127:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    h_load = do_load;
    h_in   = h;
    start  = 1'b1;
    @(negedge clk);
    h_load = 1'b0;
    start  = 1'b0;
    prev_hs = -1;
    hs_cyc  = 0;
    foreach (cur_blk[i]) begin
      in_valid = 1'b1;
      in_data  = cur_blk[i];
      in_last  = (i == cur_blk.size() - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check({name, " in_ready timeout"}, 128'(in_ready), 128'd1);
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        return;
      end
      hs_cyc = cyc;
      if (chk_lat && prev_hs >= 0)
        check({name, " handshake gap"}, 128'(hs_cyc - prev_hs), 128'(MUL_LAT + 1));
      prev_hs = hs_cyc;
      @(negedge clk);
      if (inject && i == 0) begin
        h_load = 1'b1;
        h_in   = ~h;
        @(negedge clk);
        h_load = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    e = exp_q.pop_front();
    check({name, " out_valid"}, 128'(out_valid), 128'd1);
    if (chk_lat)
      check({name, " out_valid latency"}, 128'(cyc - hs_cyc), 128'(MUL_LAT + 1));
    check({name, " tag"}, out_tag, e);
    check({name, " blk_cnt"}, 128'(blk_cnt), 128'(cur_blk.size()));
    check({name, " busy in DONE"}, 128'(busy), 128'd1);
    for (int k = 0; k < hold; k++) begin
      if (inject && k == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " hold valid"}, 128'(out_valid), 128'd1);
      check({name, " hold tag"}, out_tag, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid drop"}, 128'(out_valid), 128'd0);
    check({name, " idle busy"}, 128'(busy), 128'd0);
    check({name, " tag kept"}, out_tag, e);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string        name;
    logic [127:0] h;
    int           n;
    logic [127:0] b0, b1, b2;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [127:0] ha, hb;
    tbl[0] = '{"zero_h", 128'd0, 3, 128'hDEADBEEF_00112233_44556677_8899AABB,
               128'h1, 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0, 128'd0};
    tbl[1] = '{"identity", {1'b1, 127'd0}, 2, 128'h0123456789ABCDEF_FEDCBA9876543210,
               128'hFFFFFFFFFFFFFFFF_0000000000000000, 128'd0,
               128'hFEDCBA9876543210_FEDCBA9876543210};
    tbl[2] = '{"reduction", {2'b01, 126'd0}, 1, 128'h1, 128'd0, 128'd0, {8'hE1, 120'd0}};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 128'(in_ready), 128'd0);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset out_tag", out_tag, 128'd0);
    check("reset blk_cnt", 128'(blk_cnt), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", 128'(in_ready), 128'd0);

    for (int i = 0; i < 3; i++) begin
      cur_blk.delete();
      cur_blk.push_back(tbl[i].b0);
      if (tbl[i].n > 1) cur_blk.push_back(tbl[i].b1);
      if (tbl[i].n > 2) cur_blk.push_back(tbl[i].b2);
      run_hash(tbl[i].name, tbl[i].h, 1'b1, 1'b0, 1, 1'b0, tbl[i].exp);
    end

    // latency and hold with in_valid held high
    ha = rnd128();
    cur_blk.delete();
    for (int i = 0; i < 3; i++) cur_blk.push_back(rnd128());
    run_hash("latency", ha, 1'b1, 1'b0, 5, 1'b1, ghash_ref(ha, cur_blk));

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      ha = rnd128();
      cur_blk.delete();
      for (int i = 0; i < $urandom_range(1, 5); i++) cur_blk.push_back(rnd128());
      run_hash("random", ha, 1'b1, 1'b0, $urandom_range(0, 3), 1'b0, ghash_ref(ha, cur_blk));
    end

    // ignored controls, then a run in IDLE without h_load keeps the old H
    ha = rnd128();
    cur_blk.delete();
    for (int i = 0; i < 2; i++) cur_blk.push_back(rnd128());
    run_hash("ignored ctl", ha, 1'b1, 1'b1, 3, 1'b0, ghash_ref(ha, cur_blk));
    cur_blk.delete();
    for (int i = 0; i < 2; i++) cur_blk.push_back(rnd128());
    run_hash("old H reuse", ha, 1'b0, 1'b0, 0, 1'b0, ghash_ref(ha, cur_blk));

    // async reset mid-MUL
    hb = rnd128();
    @(negedge clk);
    h_load = 1'b1;
    h_in   = hb;
    start  = 1'b1;
    @(negedge clk);
    h_load   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = rnd128();
    in_last  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-MUL reset in_ready", 128'(in_ready), 128'd0);
    check("mid-MUL reset out_valid", 128'(out_valid), 128'd0);
    check("mid-MUL reset busy", 128'(busy), 128'd0);
    check("mid-MUL reset out_tag", out_tag, 128'd0);
    check("mid-MUL reset blk_cnt", 128'(blk_cnt), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // H was cleared by reset: a run without h_load hashes with H=0
    cur_blk.delete();
    for (int i = 0; i < 2; i++) cur_blk.push_back(rnd128());
    run_hash("post-reset H cleared", hb, 1'b0, 1'b0, 0, 1'b0, 128'd0);
    cur_blk.delete();
    for (int i = 0; i < 3; i++) cur_blk.push_back(rnd128());
    run_hash("post-reset fresh", hb, 1'b1, 1'b0, 1, 1'b1, ghash_ref(hb, cur_blk));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
